output_p4_interface: RTL

Merges the four virtual-switch output streams (one per P4 vSwitch instance) back into the single AXI4-Stream toward the output queues. It is the egress counterpart of the ingress demultiplexer. Arbitration is packet-granular round-robin: once an input is granted, it keeps the output until its tlast beat is accepted. The block also keeps one forwarded-packet counter per input.

---
 rtl/p4vbox_pkg.sv | 30 +++
 rtl/output_p4_interface_if.sv | 15 +
 rtl/rr_arbiter_4.sv | 31 +++
 rtl/output_p4_interface.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/p4vbox_pkg.sv
// Shared definitions for the P4 vSwitch box: instance count, FSM encoding,
// SUME tuser field offsets and a small index helper.
package p4vbox_pkg;

    localparam int NUM_VS       = 4;
    localparam int VS_IDX_WIDTH = 2;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } opi_state_t;

    // SUME tuser layout
    localparam int PKT_LEN_LSB    = 0;
    localparam int PKT_LEN_WIDTH  = 16;
    localparam int SRC_PORT_LSB   = 16;
    localparam int SRC_PORT_WIDTH = 8;
    localparam int DST_PORT_LSB   = 24;
    localparam int DST_PORT_WIDTH = 8;
    localparam int VS_TAG_LSB     = 32;

    // Index 'off' positions past 'idx', wrapping over the vSwitch count.
    function automatic logic [VS_IDX_WIDTH-1:0] vs_next(
        input logic [VS_IDX_WIDTH-1:0] idx,
        input int unsigned             off
    );
        return idx + VS_IDX_WIDTH'(off);
    endfunction

endpackage

// File: rtl/output_p4_interface_if.sv
// AXI4-Stream bundle used for the vSwitch inputs and the merged output.
interface output_p4_interface_if #(
    parameter int DATA_W = 256,
    parameter int USER_W = 128
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic [USER_W-1:0]   tuser;
    logic                tvalid;
    logic                tready;
    logic                tlast;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/rr_arbiter_4.sv
// Rotating-priority arbiter: grants the first requester after last_grant.
module rr_arbiter_4
    import p4vbox_pkg::*;
(
    input  logic [NUM_VS-1:0]       req,
    input  logic [VS_IDX_WIDTH-1:0] last_grant,
    output logic [NUM_VS-1:0]       gnt_oh,
    output logic [VS_IDX_WIDTH-1:0] gnt_idx,
    output logic                    gnt_vld
);

    logic [VS_IDX_WIDTH-1:0] cand;

    // Walk from farthest to nearest so the nearest requester overrides.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int i = NUM_VS; i >= 1; i--) begin
            cand = vs_next(last_grant, i);
            if (req[cand]) begin
                gnt_oh       = '0;
                gnt_oh[cand] = 1'b1;
                gnt_idx      = cand;
                gnt_vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_p4_interface.sv
// Merges four vSwitch AXI4-Stream outputs into one with packet-granular
// round-robin arbitration. Optional OPI_VS_TAG_EN stamps the source id in tuser.
module output_p4_interface
    import p4vbox_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int CNT_WIDTH            = 32
) (
    input  logic                 axis_aclk,
    input  logic                 axis_reset,
    output_p4_interface_if.slave  s_axis_0,
    output_p4_interface_if.slave  s_axis_1,
    output_p4_interface_if.slave  s_axis_2,
    output_p4_interface_if.slave  s_axis_3,
    output_p4_interface_if.master m_axis,
    output logic [CNT_WIDTH-1:0] pkt_cnt_0,
    output logic [CNT_WIDTH-1:0] pkt_cnt_1,
    output logic [CNT_WIDTH-1:0] pkt_cnt_2,
    output logic [CNT_WIDTH-1:0] pkt_cnt_3
);

    localparam int SDW = C_S_AXIS_DATA_WIDTH;
    localparam int SUW = C_S_AXIS_TUSER_WIDTH;
    localparam int MDW = C_M_AXIS_DATA_WIDTH;
    localparam int MUW = C_M_AXIS_TUSER_WIDTH;

    logic [NUM_VS-1:0]            s_valid, s_last, s_ready;
    logic [NUM_VS-1:0][SDW-1:0]   s_data;
    logic [NUM_VS-1:0][SDW/8-1:0] s_keep;
    logic [NUM_VS-1:0][SUW-1:0]   s_user;

    assign s_valid = {s_axis_3.tvalid, s_axis_2.tvalid, s_axis_1.tvalid, s_axis_0.tvalid};
    assign s_last  = {s_axis_3.tlast,  s_axis_2.tlast,  s_axis_1.tlast,  s_axis_0.tlast};
    assign s_data  = {s_axis_3.tdata,  s_axis_2.tdata,  s_axis_1.tdata,  s_axis_0.tdata};
    assign s_keep  = {s_axis_3.tkeep,  s_axis_2.tkeep,  s_axis_1.tkeep,  s_axis_0.tkeep};
    assign s_user  = {s_axis_3.tuser,  s_axis_2.tuser,  s_axis_1.tuser,  s_axis_0.tuser};

    assign s_axis_0.tready = s_ready[0];
    assign s_axis_1.tready = s_ready[1];
    assign s_axis_2.tready = s_ready[2];
    assign s_axis_3.tready = s_ready[3];

    opi_state_t              state, state_nxt;
    logic [VS_IDX_WIDTH-1:0] grant, last_grant;
    logic [NUM_VS-1:0]       grant_oh;
    logic [NUM_VS-1:0]       arb_oh;
    logic [VS_IDX_WIDTH-1:0] arb_idx;
    logic                    arb_vld;

    logic [MDW-1:0]   m_tdata;
    logic [MDW/8-1:0] m_tkeep;
    logic [MUW-1:0]   m_tuser;
    logic             m_tvalid, m_tlast;
    logic [MUW-1:0]   ld_user;
    logic             out_rdy, hs, hs_last;

    logic [NUM_VS-1:0][CNT_WIDTH-1:0] cnt;

    rr_arbiter_4 u_arb (
        .req        (s_valid),
        .last_grant (last_grant),
        .gnt_oh     (arb_oh),
        .gnt_idx    (arb_idx),
        .gnt_vld    (arb_vld)
    );

    // A new beat is taken whenever the output register is empty or draining.
    assign out_rdy = !m_tvalid || m_axis.tready;
    assign s_ready = (state == PKT && out_rdy) ? grant_oh : '0;
    assign hs      = |(s_ready & s_valid);
    assign hs_last = hs && s_last[grant];

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_vld) state_nxt = PKT;
            PKT:     if (hs_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // last_grant resets to the top index so input 0 wins first.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            grant      <= '0;
            grant_oh   <= '0;
            last_grant <= VS_IDX_WIDTH'(NUM_VS - 1);
        end else if (state == IDLE && arb_vld) begin
            grant      <= arb_idx;
            grant_oh   <= arb_oh;
            last_grant <= arb_idx;
        end
    end

`ifdef OPI_VS_TAG_EN
    always_comb begin
        ld_user = MUW'(s_user[grant]);
        ld_user[VS_TAG_LSB +: VS_IDX_WIDTH] = grant;
    end
`else
    assign ld_user = MUW'(s_user[grant]);
`endif

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tuser  <= '0;
            m_tlast  <= 1'b0;
            m_tvalid <= 1'b0;
        end else if (hs) begin
            m_tdata  <= MDW'(s_data[grant]);
            m_tkeep  <= (MDW/8)'(s_keep[grant]);
            m_tuser  <= ld_user;
            m_tlast  <= s_last[grant];
            m_tvalid <= 1'b1;
        end else if (m_axis.tready) begin
            m_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            cnt <= '0;
        end else begin
            for (int n = 0; n < NUM_VS; n++)
                if (hs_last && grant_oh[n]) cnt[n] <= cnt[n] + CNT_WIDTH'(1);
        end
    end

    assign m_axis.tdata  = m_tdata;
    assign m_axis.tkeep  = m_tkeep;
    assign m_axis.tuser  = m_tuser;
    assign m_axis.tlast  = m_tlast;
    assign m_axis.tvalid = m_tvalid;

    assign pkt_cnt_0 = cnt[0];
    assign pkt_cnt_1 = cnt[1];
    assign pkt_cnt_2 = cnt[2];
    assign pkt_cnt_3 = cnt[3];

endmodule
